tile_vga_renderer: RTL and testbench

- Renders one 2048 board tile into the VGA pixel stream: background fill, plus the tile value 2^state drawn in centred decimal digits with leading-zero suppression.
- The tile value is computed in hardware by a sequential binary-to-BCD (shift-add-3) converter. There is no per-value lookup table.
- Tile position, size and exponent width are parameters, so one instance per board cell is placed by the board compositor.
- Glyph rows come from the shared external font ROM; new values are committed on a frame boundary, so a tile never tears mid-frame.

---
 rtl/tile_vga_renderer.sv | 209 ++++++++++++++++++++
 tb/tb_tile_vga_renderer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_vga_renderer.sv
// One 2048 board tile: background fill plus centred decimal value 2^state, converted by a shift-add-3 BCD engine.
// Optional pop animation border is compiled in with `define TILE_POP_EN.
module tile_vga_renderer #(
  parameter logic [11:0] TILE_X     = 12'd0,
  parameter logic [11:0] TILE_Y     = 12'd0,
  parameter logic [11:0] TILE_SIZE  = 12'd106,
  parameter int          EXP_W      = 4,
  parameter int          POP_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EXP_W-1:0] state,
  input  logic [11:0]      h_cnt,
  input  logic [11:0]      v_cnt,
  input  logic [15:0]      font_row,
  output logic [3:0]       font_number,
  output logic [4:0]       font_line,
  output logic [11:0]      vga_data,
  output logic             in_tile,
  output logic             busy
);

  // state      | meaning
  // IDLE       | committed value matches state input
  // LOAD       | bin = 1<<snap, BCD cleared
  // SHIFT      | 16 shift-add-3 iterations
  // WAIT_FRAME | result held until the next frame start, then committed
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_FRAME} fsm_t;
  fsm_t fsm, fsm_next;

  logic [EXP_W-1:0] snap, c_state;
  logic [EXP_W+3:0] snap_ext, c_ext;
  logic [3:0]       snap_sat, c_sat;
  logic [15:0]      bin;
  logic [19:0]      bcd, bcd_adj, c_bcd;
  logic [2:0]       c_n, n_calc;
  logic [3:0]       cnt;
  logic             frame_start;

  assign frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign snap_ext    = {4'b0, snap};
  assign c_ext       = {4'b0, c_state};
  assign snap_sat    = (snap_ext > (EXP_W+4)'(15)) ? 4'hF : snap_ext[3:0];
  assign c_sat       = (c_ext > (EXP_W+4)'(15)) ? 4'hF : c_ext[3:0];

  always_comb begin
    fsm_next = fsm;
    busy     = 1'b1;
    unique case (fsm)
      IDLE: begin
        busy = 1'b0;
        if (state != c_state) fsm_next = LOAD;
      end
      LOAD:       fsm_next = SHIFT;
      SHIFT:      if (cnt == 4'd0) fsm_next = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) fsm_next = IDLE;
      default:    fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  always_comb begin
    if      (bcd[19:16] != 4'd0) n_calc = 3'd5;
    else if (bcd[15:12] != 4'd0) n_calc = 3'd4;
    else if (bcd[11:8]  != 4'd0) n_calc = 3'd3;
    else if (bcd[7:4]   != 4'd0) n_calc = 3'd2;
    else if (bcd[3:0]   != 4'd0) n_calc = 3'd1;
    else                         n_calc = 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      c_state <= '0;
      bin     <= '0;
      bcd     <= '0;
      c_bcd   <= '0;
      c_n     <= '0;
      cnt     <= '0;
    end else begin
      unique case (fsm)
        IDLE: if (state != c_state) snap <= state;
        LOAD: begin
          bin <= (snap == '0) ? 16'd0 : (16'd1 << snap_sat);
          bcd <= '0;
          cnt <= 4'd15;
        end
        SHIFT: begin
          bcd <= {bcd_adj[18:0], bin[15]};
          bin <= {bin[14:0], 1'b0};
          cnt <= cnt - 4'd1;
        end
        WAIT_FRAME: if (frame_start) begin
          c_bcd   <= bcd;
          c_n     <= n_calc;
          c_state <= snap;
        end
        default: ;
      endcase
    end
  end

  logic [11:0] lx, ly, text_w, x0, y0, tx, ty;
  logic        in_tile_c, in_text_c, border_c;
  logic [2:0]  dig_idx;
  logic [3:0]  dig;

  assign lx        = h_cnt - TILE_X;
  assign ly        = v_cnt - TILE_Y;
  assign in_tile_c = (lx < TILE_SIZE) && (ly < TILE_SIZE);
  assign text_w    = {5'b0, c_n, 4'b0};
  assign x0        = (TILE_SIZE - text_w) >> 1;
  assign y0        = (TILE_SIZE - 12'd32) >> 1;
  assign tx        = lx - x0;
  assign ty        = ly - y0;
  assign in_text_c = (lx >= x0) && (tx < text_w) && (ly >= y0) && (ty < 12'd32);
  // Digit 0 on screen is the most significant of the c_n valid nibbles.
  assign dig_idx   = c_n - 3'd1 - tx[6:4];

  always_comb begin
    dig = 4'hF;
    case (dig_idx)
      3'd0: dig = c_bcd[3:0];
      3'd1: dig = c_bcd[7:4];
      3'd2: dig = c_bcd[11:8];
      3'd3: dig = c_bcd[15:12];
      3'd4: dig = c_bcd[19:16];
      default: dig = 4'hF;
    endcase
  end

  assign font_number = in_text_c ? dig : 4'hF;
  assign font_line   = ty[4:0];

`ifdef TILE_POP_EN
  localparam int PW = $clog2(POP_FRAMES + 1);
  logic [PW-1:0] pop;
  logic [11:0]   pop2;

  assign pop2     = 12'(pop) << 1;
  assign border_c = (pop != '0) &&
                    ((lx < pop2) || (ly < pop2) ||
                     (lx >= TILE_SIZE - pop2) || (ly >= TILE_SIZE - pop2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   pop <= '0;
    else if (fsm == WAIT_FRAME && frame_start && snap != '0)   pop <= PW'(POP_FRAMES);
    else if (frame_start && pop != '0)                         pop <= pop - 1'b1;
  end
`else
  assign border_c = 1'b0;
`endif

  logic [11:0] bg, fg;
  always_comb begin
    case (c_sat)
      4'd0:    bg = 12'hCCB;
      4'd1:    bg = 12'hEED;
      4'd2:    bg = 12'hEEC;
      4'd3:    bg = 12'hFB7;
      4'd4:    bg = 12'hF96;
      4'd5:    bg = 12'hF75;
      4'd6:    bg = 12'hF53;
      4'd7:    bg = 12'hED7;
      4'd8:    bg = 12'hEC6;
      4'd9:    bg = 12'hEC5;
      4'd10:   bg = 12'hEC3;
      4'd11:   bg = 12'hEC2;
      default: bg = 12'h333;
    endcase
    fg = (c_sat == 4'd1 || c_sat == 4'd2) ? 12'h766 : 12'hFFF;
  end

  // Stage 1 runs alongside the font ROM read, stage 2 forms the pixel.
  logic       s1_tile, s1_text, s1_border;
  logic [3:0] s1_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_tile   <= 1'b0;
      s1_text   <= 1'b0;
      s1_border <= 1'b0;
      s1_col    <= '0;
      vga_data  <= '0;
      in_tile   <= 1'b0;
    end else begin
      s1_tile   <= in_tile_c;
      s1_text   <= in_text_c;
      s1_border <= border_c;
      s1_col    <= tx[3:0];
      in_tile   <= s1_tile;
      if (s1_text && font_row[4'd15 - s1_col]) vga_data <= fg;
      else if (s1_tile && s1_border)           vga_data <= 12'hBBA;
      else if (s1_tile)                        vga_data <= bg;
      else                                     vga_data <= 12'h000;
    end
  end

endmodule

// File: tb/tb_tile_vga_renderer.sv
// Directed bench for tile_vga_renderer placed at (100,50), size 106; test ROM lights column == digit value.
module tb_tile_vga_renderer;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state;
  logic [11:0] h_cnt, v_cnt;
  logic [15:0] font_row;
  logic [3:0]  font_number;
  logic [4:0]  font_line;
  logic [11:0] vga_data;
  logic        in_tile;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [11:0] px_d;
  logic        px_t;

  tile_vga_renderer #(
    .TILE_X(12'd100), .TILE_Y(12'd50), .TILE_SIZE(12'd106), .EXP_W(4), .POP_FRAMES(4)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .font_row(font_row), .font_number(font_number), .font_line(font_line),
    .vga_data(vga_data), .in_tile(in_tile), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    font_row <= (font_number == 4'hF) ? 16'h0000 : (16'h8000 >> font_number);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    h_cnt = 12'd5;
    v_cnt = 12'd5;
  endtask

  task automatic frame();
    h_cnt = 12'd0;
    v_cnt = 12'd0;
    tick();
    park();
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v);
    h_cnt = h;
    v_cnt = v;
    tick();
    tick();
    px_d = vga_data;
    px_t = in_tile;
    park();
  endtask

  task automatic chk_px(input string name, input logic [11:0] exp_d, input logic exp_t);
    total++;
    if (px_d !== exp_d || px_t !== exp_t) begin
      bad++;
      $display("FAIL %s got vga=%h in_tile=%b exp vga=%h in_tile=%b", name, px_d, px_t, exp_d, exp_t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 4'd0; park();
    tick(); tick();
    total++;
    if (vga_data !== 12'h000 || in_tile !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got vga=%h tile=%b busy=%b exp 000 0 0", vga_data, in_tile, busy);
    end
    rst = 1'b0;
    tick();
    h_cnt = 12'd145; v_cnt = 12'd87; #1;
    total++;
    if (font_number !== 4'hF) begin
      bad++;
      $display("FAIL reset_blank got=%h exp=F", font_number);
    end
    pix(12'd110, 12'd60);
    chk_px("reset_bg", 12'hCCB, 1'b1);
  endtask

  task automatic test_convert_11();
    state = 4'd11;
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL c11_busy_load got=%b exp=1", busy); end
    repeat (24) tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL c11_busy_wait got=%b exp=1", busy); end
    pix(12'd123, 12'd87);
    chk_px("c11_no_tear", 12'hCCB, 1'b1);
    frame();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL c11_busy_done got=%b exp=0", busy); end
    h_cnt = 12'd121; v_cnt = 12'd87; #1;
    total++;
    if (font_number !== 4'd2 || font_line !== 5'd0) begin
      bad++; $display("FAIL c11_fn_first got num=%h line=%0d exp 2 0", font_number, font_line);
    end
    h_cnt = 12'd184; #1;
    total++;
    if (font_number !== 4'd8) begin bad++; $display("FAIL c11_fn_last got=%h exp=8", font_number); end
    h_cnt = 12'd185; #1;
    total++;
    if (font_number !== 4'hF) begin bad++; $display("FAIL c11_fn_right got=%h exp=F", font_number); end
    h_cnt = 12'd120; #1;
    total++;
    if (font_number !== 4'hF) begin bad++; $display("FAIL c11_fn_left got=%h exp=F", font_number); end
    h_cnt = 12'd121; v_cnt = 12'd118; #1;
    total++;
    if (font_number !== 4'd2 || font_line !== 5'd31) begin
      bad++; $display("FAIL c11_fn_bottom got num=%h line=%0d exp 2 31", font_number, font_line);
    end
    v_cnt = 12'd119; #1;
    total++;
    if (font_number !== 4'hF) begin bad++; $display("FAIL c11_fn_below got=%h exp=F", font_number); end
    park();
    tick();
    pix(12'd121, 12'd87); chk_px("c11_px_d2_col0", 12'hEC2, 1'b1);
    pix(12'd123, 12'd87); chk_px("c11_px_d2_col2", 12'hFFF, 1'b1);
    pix(12'd137, 12'd87); chk_px("c11_px_d0_col0", 12'hFFF, 1'b1);
    pix(12'd177, 12'd87); chk_px("c11_px_d8_col8", 12'hFFF, 1'b1);
    pix(12'd176, 12'd87); chk_px("c11_px_d8_col7", 12'hEC2, 1'b1);
  endtask

  task automatic test_convert_15();
    state = 4'd15;
    repeat (25) tick();
    frame();
    h_cnt = 12'd113; v_cnt = 12'd92; #1;
    total++;
    if (font_number !== 4'd3 || font_line !== 5'd5) begin
      bad++; $display("FAIL c15_fn_first got num=%h line=%0d exp 3 5", font_number, font_line);
    end
    h_cnt = 12'd145; #1;
    total++;
    if (font_number !== 4'd7) begin bad++; $display("FAIL c15_fn_mid got=%h exp=7", font_number); end
    h_cnt = 12'd177; #1;
    total++;
    if (font_number !== 4'd8) begin bad++; $display("FAIL c15_fn_last got=%h exp=8", font_number); end
    h_cnt = 12'd193; #1;
    total++;
    if (font_number !== 4'hF) begin bad++; $display("FAIL c15_fn_right got=%h exp=F", font_number); end
    h_cnt = 12'd112; #1;
    total++;
    if (font_number !== 4'hF) begin bad++; $display("FAIL c15_fn_left got=%h exp=F", font_number); end
    park();
    tick();
    pix(12'd152, 12'd92); chk_px("c15_px_lit", 12'hFFF, 1'b1);
    pix(12'd151, 12'd92); chk_px("c15_px_bg", 12'h333, 1'b1);
  endtask

  task automatic test_change_during_shift();
    state = 4'd3;
    tick();
    repeat (5) tick();
    state = 4'd5;
    repeat (20) tick();
    frame();
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL chg_restart got=%b exp=1", busy); end
    pix(12'd153, 12'd87); chk_px("chg_8_lit", 12'hFFF, 1'b1);
    pix(12'd145, 12'd87); chk_px("chg_8_bg", 12'hFB7, 1'b1);
    repeat (20) tick();
    frame();
    pix(12'd140, 12'd87); chk_px("chg_32_d3", 12'hFFF, 1'b1);
    pix(12'd137, 12'd87); chk_px("chg_32_bg", 12'hF75, 1'b1);
    pix(12'd155, 12'd87); chk_px("chg_32_d2", 12'hFFF, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    pix(12'd100, 12'd50); chk_px("rms_before", 12'hF75, 1'b1);
    h_cnt = 12'd100; v_cnt = 12'd50;
    state = 4'd3;
    tick();
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    total++;
    if (vga_data !== 12'h000 || in_tile !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rms_async got vga=%h tile=%b busy=%b exp 000 0 0", vga_data, in_tile, busy);
    end
    tick();
    rst = 1'b0;
    park();
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rms_reconvert got=%b exp=1", busy); end
    repeat (20) tick();
    frame();
    pix(12'd153, 12'd87); chk_px("rms_8_lit", 12'hFFF, 1'b1);
    pix(12'd145, 12'd87); chk_px("rms_8_bg", 12'hFB7, 1'b1);
  endtask

  task automatic test_outside();
    pix(12'd99, 12'd50);   chk_px("out_left", 12'h000, 1'b0);
    pix(12'd206, 12'd50);  chk_px("out_right", 12'h000, 1'b0);
    pix(12'd100, 12'd49);  chk_px("out_above", 12'h000, 1'b0);
    pix(12'd205, 12'd155); chk_px("in_corner", 12'hFB7, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_b [5];
    exp_b[0] = 12'hFB7; exp_b[1] = 12'hFB7; exp_b[2] = 12'hFFF;
    exp_b[3] = 12'hFB7; exp_b[4] = 12'hFB7;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin h_cnt = 12'd151 + 12'(i); v_cnt = 12'd87; end
      else park();
      tick();
      if (i >= 1) begin
        total++;
        if (vga_data !== exp_b[i-1]) begin
          bad++;
          $display("FAIL b2b_px%0d got=%h exp=%h", i - 1, vga_data, exp_b[i-1]);
        end
      end
    end
  endtask

`ifdef TILE_POP_EN
  task automatic test_pop();
    state = 4'd0;
    repeat (25) tick();
    frame();
    state = 4'd1;
    repeat (25) tick();
    frame();
    pix(12'd107, 12'd100); chk_px("pop4_in", 12'hBBA, 1'b1);
    pix(12'd108, 12'd100); chk_px("pop4_out", 12'hEED, 1'b1);
    pix(12'd198, 12'd100); chk_px("pop4_right", 12'hBBA, 1'b1);
    pix(12'd197, 12'd100); chk_px("pop4_right_in", 12'hEED, 1'b1);
    frame();
    pix(12'd105, 12'd100); chk_px("pop3_in", 12'hBBA, 1'b1);
    pix(12'd106, 12'd100); chk_px("pop3_out", 12'hEED, 1'b1);
    frame();
    frame();
    pix(12'd101, 12'd100); chk_px("pop1_in", 12'hBBA, 1'b1);
    pix(12'd102, 12'd100); chk_px("pop1_out", 12'hEED, 1'b1);
    frame();
    pix(12'd100, 12'd100); chk_px("pop0_none", 12'hEED, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_convert_11();
    test_convert_15();
    test_change_during_shift();
    test_reset_mid_shift();
    test_outside();
    test_back_to_back();
`ifdef TILE_POP_EN
    test_pop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
